// File: rtl/toggle_pkg.sv
// Shared types and constants for the toggle request conditioner.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // Counter must hold values 0..cycles without wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit multi-flop synchronizer; pure shift chain with no logic between stages.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sr <= '0;
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], d};
        end
    end

    assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/toggle_pulse_gen.sv
// Turns a raw bouncy input into a debounced level plus a one-cycle toggle request
// for a downstream T flip-flop on the same clock.
module toggle_pulse_gen
    import toggle_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic enable,
    output logic t_pulse,
    output logic btn_level,
    output logic busy
);

    localparam int unsigned   CW        = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam bit            PASS_THRU = (DEBOUNCE_CYCLES == 1);
    localparam bit            FIRE_RISE = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
    localparam bit            FIRE_FALL = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);

    logic          sync_q;
    state_e        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          level_d;
    logic          pulse_d;
    logic          busy_d;
    logic          rise_ev;
    logic          fall_ev;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_q)
    );

    // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = btn_level;
        rise_ev = 1'b0;
        fall_ev = 1'b0;
        case (state)
            IDLE_LO: begin
                if (sync_q) begin
                    if (PASS_THRU) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_ev = 1'b1;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_ev = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!sync_q) begin
                    if (PASS_THRU) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_ev = 1'b1;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_ev = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
        // The !t_pulse term keeps requests from ever landing on back-to-back cycles.
        pulse_d = ((rise_ev && FIRE_RISE) || (fall_ev && FIRE_FALL)) && enable && !t_pulse;
        busy_d  = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE_LO;
            cnt       <= '0;
            btn_level <= 1'b0;
            t_pulse   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            btn_level <= level_d;
            t_pulse   <= pulse_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench: four instances (rise/fall/both with 4-cycle debounce, rise with 1-cycle debounce)
// share the same stimulus.
module tb_toggle_pulse_gen;

    logic clk;
    logic rst;
    logic btn_in;
    logic enable;

    logic r_pulse, r_level, r_busy;
    logic f_pulse, f_level, f_busy;
    logic b_pulse, b_level, b_busy;
    logic q_pulse, q_level, q_busy;
    logic tq;

    int n_cmp;
    int n_err;

    toggle_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_rise (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .t_pulse(r_pulse), .btn_level(r_level), .busy(r_busy));

    toggle_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) u_fall (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .t_pulse(f_pulse), .btn_level(f_level), .busy(f_busy));

    toggle_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_both (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .t_pulse(b_pulse), .btn_level(b_level), .busy(b_busy));

    toggle_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0)) u_fast (
        .clk(clk), .rst(rst), .btn_in(btn_in), .enable(enable),
        .t_pulse(q_pulse), .btn_level(q_level), .busy(q_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream T flip-flop driven by the both-edges instance.
    always @(posedge clk) begin
        if (rst) tq <= 1'b0;
        else if (b_pulse) tq <= ~tq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        n_cmp++; if (r_pulse !== 1'b0) begin n_err++; $display("FAIL reset_r_pulse: got %b want 0", r_pulse); end
        n_cmp++; if (r_level !== 1'b0) begin n_err++; $display("FAIL reset_r_level: got %b want 0", r_level); end
        n_cmp++; if (r_busy  !== 1'b0) begin n_err++; $display("FAIL reset_r_busy: got %b want 0", r_busy); end
        n_cmp++; if (f_pulse !== 1'b0) begin n_err++; $display("FAIL reset_f_pulse: got %b want 0", f_pulse); end
        n_cmp++; if (b_level !== 1'b0) begin n_err++; $display("FAIL reset_b_level: got %b want 0", b_level); end
        n_cmp++; if (q_level !== 1'b0) begin n_err++; $display("FAIL reset_q_level: got %b want 0", q_level); end
        n_cmp++; if (q_busy  !== 1'b0) begin n_err++; $display("FAIL reset_q_busy: got %b want 0", q_busy); end
        n_cmp++; if (tq      !== 1'b0) begin n_err++; $display("FAIL reset_tq: got %b want 0", tq); end
        rst = 1'b0;
    endtask

    // Offset o = edges after the edge that first samples btn_in high.
    task automatic test_clean_press();
        do_reset();
        for (int o = 0; o < 10; o++) begin
            btn_in = 1'b1;
            tick();
            n_cmp++; if (r_pulse !== (o == 5)) begin n_err++; $display("FAIL press_r_pulse: got %b want %b o=%0d", r_pulse, (o == 5), o); end
            n_cmp++; if (r_level !== (o >= 5)) begin n_err++; $display("FAIL press_r_level: got %b want %b o=%0d", r_level, (o >= 5), o); end
            n_cmp++; if (r_busy !== (o >= 2 && o <= 4)) begin n_err++; $display("FAIL press_r_busy: got %b want %b o=%0d", r_busy, (o >= 2 && o <= 4), o); end
            n_cmp++; if (f_pulse !== 1'b0) begin n_err++; $display("FAIL press_f_pulse: got %b want 0 o=%0d", f_pulse, o); end
            n_cmp++; if (q_pulse !== (o == 2)) begin n_err++; $display("FAIL press_q_pulse: got %b want %b o=%0d", q_pulse, (o == 2), o); end
            n_cmp++; if (q_level !== (o >= 2)) begin n_err++; $display("FAIL press_q_level: got %b want %b o=%0d", q_level, (o >= 2), o); end
            n_cmp++; if (q_busy !== 1'b0) begin n_err++; $display("FAIL press_q_busy: got %b want 0 o=%0d", q_busy, o); end
        end
    endtask

    task automatic test_bounce_reject();
        logic busy_seen;
        busy_seen = 1'b0;
        do_reset();
        for (int o = 0; o < 16; o++) begin
            btn_in = (o < 8) ? (((o / 2) % 2) == 0) : 1'b0;
            tick();
            busy_seen = busy_seen | r_busy;
            n_cmp++; if (r_level !== 1'b0) begin n_err++; $display("FAIL bounce_r_level: got %b want 0 o=%0d", r_level, o); end
            n_cmp++; if (r_pulse !== 1'b0) begin n_err++; $display("FAIL bounce_r_pulse: got %b want 0 o=%0d", r_pulse, o); end
            n_cmp++; if (b_pulse !== 1'b0) begin n_err++; $display("FAIL bounce_b_pulse: got %b want 0 o=%0d", b_pulse, o); end
        end
        n_cmp++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL bounce_busy_seen: got %b want 1", busy_seen); end
        n_cmp++; if (r_busy !== 1'b0) begin n_err++; $display("FAIL bounce_busy_end: got %b want 0", r_busy); end
    endtask

    task automatic test_bounce_settle();
        int npulse;
        npulse = 0;
        do_reset();
        // 3-cycle glitch, 2 cycles low, then held high from offset 5.
        for (int o = 0; o < 16; o++) begin
            btn_in = (o < 3) || (o >= 5);
            tick();
            if (r_pulse === 1'b1) npulse++;
            n_cmp++; if (r_pulse !== (o == 10)) begin n_err++; $display("FAIL settle_r_pulse: got %b want %b o=%0d", r_pulse, (o == 10), o); end
            n_cmp++; if (r_level !== (o >= 10)) begin n_err++; $display("FAIL settle_r_level: got %b want %b o=%0d", r_level, (o >= 10), o); end
        end
        n_cmp++; if (npulse != 1) begin n_err++; $display("FAIL settle_count: got %0d want 1", npulse); end
    endtask

    task automatic test_press_release();
        do_reset();
        for (int o = 0; o < 32; o++) begin
            btn_in = (o < 20);
            tick();
            n_cmp++; if (b_pulse !== (o == 5 || o == 25)) begin n_err++; $display("FAIL pr_b_pulse: got %b want %b o=%0d", b_pulse, (o == 5 || o == 25), o); end
            n_cmp++; if (r_pulse !== (o == 5)) begin n_err++; $display("FAIL pr_r_pulse: got %b want %b o=%0d", r_pulse, (o == 5), o); end
            n_cmp++; if (f_pulse !== (o == 25)) begin n_err++; $display("FAIL pr_f_pulse: got %b want %b o=%0d", f_pulse, (o == 25), o); end
            n_cmp++; if (f_level !== (o >= 5 && o < 25)) begin n_err++; $display("FAIL pr_f_level: got %b want %b o=%0d", f_level, (o >= 5 && o < 25), o); end
            n_cmp++; if (f_busy !== ((o >= 2 && o <= 4) || (o >= 22 && o <= 24))) begin n_err++; $display("FAIL pr_f_busy: got %b o=%0d", f_busy, o); end
            if (o == 15) begin
                n_cmp++; if (tq !== 1'b1) begin n_err++; $display("FAIL pr_tq_mid: got %b want 1", tq); end
            end
            if (o == 31) begin
                n_cmp++; if (tq !== 1'b0) begin n_err++; $display("FAIL pr_tq_end: got %b want 0", tq); end
            end
        end
    endtask

    task automatic test_enable_gate();
        do_reset();
        for (int o = 0; o < 32; o++) begin
            enable = (o >= 10);
            btn_in = (o < 20);
            tick();
            n_cmp++; if (b_pulse !== (o == 25)) begin n_err++; $display("FAIL en_b_pulse: got %b want %b o=%0d", b_pulse, (o == 25), o); end
            n_cmp++; if (b_level !== (o >= 5 && o < 25)) begin n_err++; $display("FAIL en_b_level: got %b want %b o=%0d", b_level, (o >= 5 && o < 25), o); end
            n_cmp++; if (r_pulse !== 1'b0) begin n_err++; $display("FAIL en_r_pulse: got %b want 0 o=%0d", r_pulse, o); end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int o = 0; o < 15; o++) begin
            btn_in = 1'b1;
            rst    = (o == 4);
            tick();
            if (o == 3) begin
                n_cmp++; if (r_busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_pre: got %b want 1", r_busy); end
            end
            if (o == 4) begin
                n_cmp++; if (r_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy_rst: got %b want 0", r_busy); end
                n_cmp++; if (q_level !== 1'b0) begin n_err++; $display("FAIL rmid_q_level_rst: got %b want 0", q_level); end
            end
            n_cmp++; if (r_pulse !== (o == 10)) begin n_err++; $display("FAIL rmid_r_pulse: got %b want %b o=%0d", r_pulse, (o == 10), o); end
            n_cmp++; if (r_level !== (o >= 10)) begin n_err++; $display("FAIL rmid_r_level: got %b want %b o=%0d", r_level, (o >= 10), o); end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_on_accept();
        do_reset();
        for (int o = 0; o < 14; o++) begin
            btn_in = 1'b1;
            rst    = (o == 5);
            tick();
            n_cmp++; if (r_pulse !== (o == 11)) begin n_err++; $display("FAIL racc_r_pulse: got %b want %b o=%0d", r_pulse, (o == 11), o); end
            n_cmp++; if (r_level !== (o >= 11)) begin n_err++; $display("FAIL racc_r_level: got %b want %b o=%0d", r_level, (o >= 11), o); end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        btn_in = 1'b0;
        enable = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_bounce_settle();
        test_press_release();
        test_enable_gate();
        test_reset_mid_wait();
        test_reset_on_accept();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
